cp_insert: RTL and testbench

- Cyclic-prefix inserter directly downstream of the 64-point IFFT in the OFDM modulation chain.
- Collects each 64-sample time-domain symbol into a ping-pong buffer.
- Emits 80 samples per symbol: the last 16 samples (CP), then all 64 samples in order.
- Feeds the DAC/framing stage.

---
 rtl/cp_insert.sv | 156 +++++++++++++++
 tb/tb_cp_insert.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: buffers NFFT-sample IFFT symbols in a ping-pong RAM and replays
// each one as its last NCP samples followed by the whole symbol, 1-cycle registered read.
module cp_insert #(
    parameter int NFFT = 64,
    parameter int NCP  = 16,
    parameter int W    = 11
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         valid_i,
    input  logic [W-1:0] xr_i,
    input  logic [W-1:0] xi_i,
    output logic         valid_o,
    output logic [W-1:0] yr,
    output logic [W-1:0] yi,
    output logic         sym_start,
    output logic         overflow
);
    // state  | meaning
    // S_IDLE | waiting for full[rb]
    // S_CP   | reading addresses NFFT-NCP .. NFFT-1 of bank rb
    // S_BODY | reading addresses 0 .. NFFT-1 of bank rb
    localparam int AW = $clog2(NFFT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NFFT - 1);
    localparam logic [AW-1:0] CP_ADDR   = AW'(NFFT - NCP);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

    logic [2*W-1:0] r_mem0 [NFFT];
    logic [2*W-1:0] r_mem1 [NFFT];

    logic [AW-1:0]  r_widx;
    logic           r_wb;
    logic           r_drop;
    logic [1:0]     r_full;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_raddr;
    logic [AW-1:0]  w_raddr_nxt;
    logic           r_rb;
    logic           w_rb_nxt;
    logic           w_rd_en;
    logic           w_rd_first;
    logic           w_rd_done;
    logic [1:0]     w_clr;
    logic [1:0]     w_set;
    logic [1:0]     w_full_eff;
    logic           w_ovf;
    logic           w_wr_en;
    logic           w_wr_last;
    logic [2*W-1:0] w_rdata;

    // A bank freed by the reader on this edge may be claimed by the writer on the same edge.
    always_comb begin
        w_clr = 2'b00;
        if (w_rd_done) w_clr[r_rb] = 1'b1;
    end

    assign w_full_eff = r_full & ~w_clr;
    assign w_ovf      = valid_i && (r_widx == '0) && !r_drop && w_full_eff[r_wb];
    assign w_wr_en    = valid_i && !r_drop && !w_ovf;
    assign w_wr_last  = w_wr_en && (r_widx == LAST_ADDR);

    always_comb begin
        w_set = 2'b00;
        if (w_wr_last) w_set[r_wb] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_widx   <= '0;
            r_wb     <= 1'b0;
            r_drop   <= 1'b0;
            r_full   <= 2'b00;
            overflow <= 1'b0;
        end else begin
            overflow <= w_ovf;
            r_full   <= w_full_eff | w_set;
            if (valid_i) begin
                r_widx <= r_widx + 1'b1;
                if (w_ovf)
                    r_drop <= 1'b1;
                else if (r_widx == LAST_ADDR)
                    r_drop <= 1'b0;
                if (w_wr_last) r_wb <= ~r_wb;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en && !r_wb) r_mem0[r_widx] <= {xr_i, xi_i};
        if (w_wr_en && r_wb)  r_mem1[r_widx] <= {xr_i, xi_i};
    end

    assign w_rdata = r_rb ? r_mem1[r_raddr] : r_mem0[r_raddr];

    // The read address simply wraps from NFFT-1 to 0 at the CP -> BODY boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_raddr_nxt = r_raddr;
        w_rb_nxt    = r_rb;
        w_rd_en     = 1'b0;
        w_rd_first  = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rb]) begin
                    w_state_nxt = S_CP;
                    w_raddr_nxt = CP_ADDR;
                end
            end
            S_CP: begin
                w_rd_en     = 1'b1;
                w_rd_first  = (r_raddr == CP_ADDR);
                w_raddr_nxt = r_raddr + 1'b1;
                if (r_raddr == LAST_ADDR) w_state_nxt = S_BODY;
            end
            S_BODY: begin
                w_rd_en     = 1'b1;
                w_raddr_nxt = r_raddr + 1'b1;
                if (r_raddr == LAST_ADDR) begin
                    w_rd_done = 1'b1;
                    w_rb_nxt  = ~r_rb;
                    if (r_full[~r_rb]) begin
                        w_state_nxt = S_CP;
                        w_raddr_nxt = CP_ADDR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_raddr   <= '0;
            r_rb      <= 1'b0;
            valid_o   <= 1'b0;
            sym_start <= 1'b0;
            yr        <= '0;
            yi        <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rb      <= w_rb_nxt;
            valid_o   <= w_rd_en;
            sym_start <= w_rd_first;
            yr        <= w_rd_en ? w_rdata[2*W-1:W] : '0;
            yi        <= w_rd_en ? w_rdata[W-1:0]   : '0;
        end
    end

endmodule

// File: tb/tb_cp_insert.sv
// Bench for cp_insert: stimulus streams checked cycle by cycle against a symbol-level
// timing model (accept/drop decision, output start time, CP-then-body sample order).
`timescale 1ns/1ps
module tb_cp_insert;
    localparam int NFFT = 64;
    localparam int NCP  = 16;
    localparam int W    = 11;
    localparam int MAXC = 2000;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] xr_i = '0;
    logic [W-1:0] xi_i = '0;
    logic         valid_o;
    logic         sym_start;
    logic         overflow;
    logic [W-1:0] yr;
    logic [W-1:0] yi;

    cp_insert #(.NFFT(NFFT), .NCP(NCP), .W(W)) dut (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .xr_i(xr_i), .xi_i(xi_i),
        .valid_o(valid_o), .yr(yr), .yi(yi), .sym_start(sym_start), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic         stim_v [MAXC];
    logic [W-1:0] stim_r [MAXC];
    logic [W-1:0] stim_i [MAXC];
    // packing: [24] valid, [23] sym_start, [22] overflow, [21:11] yr, [10:0] yi
    logic [2*W+2:0] exp_o [MAXC];
    logic [2*W+2:0] obs_o [MAXC];

    function automatic string fmt(logic [2*W+2:0] x);
        return $sformatf("v=%b ss=%b ov=%b yr=%0d yi=%0d", x[24], x[23], x[22],
                         $signed(x[21:11]), $signed(x[10:0]));
    endfunction

    function automatic void clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            stim_v[c] = 1'b0;
            stim_r[c] = '0;
            stim_i[c] = '0;
        end
    endfunction

    function automatic void add_sym(int start, int stride, bit ramp);
        for (int n = 0; n < NFFT; n++) begin
            int c;
            c = start + n * stride;
            stim_v[c] = 1'b1;
            stim_r[c] = ramp ? W'(n) : W'($urandom);
            stim_i[c] = ramp ? W'(-n) : W'($urandom);
        end
    endfunction

    // Symbol k completing at edge T is output from S = max(T+2, S_prev+80) for 80 cycles.
    // A symbol starting at edge F needs the bank of the accepted symbol two back, which
    // is released on that symbol's last output edge S+79; if still held, it is dropped.
    function automatic void model(int n);
        int           acc_s[$];
        int           cnt;
        int           f;
        int           k;
        int           s;
        logic [W-1:0] br [NFFT];
        logic [W-1:0] bi [NFFT];
        cnt = 0;
        f = 0;
        for (int c = 0; c < MAXC; c++) exp_o[c] = '0;
        for (int c = 0; c < n; c++) begin
            if (stim_v[c]) begin
                if (cnt == 0) f = c;
                br[cnt] = stim_r[c];
                bi[cnt] = stim_i[c];
                cnt++;
                if (cnt == NFFT) begin
                    cnt = 0;
                    k = acc_s.size();
                    if (k >= 2 && acc_s[k-2] + NFFT + NCP - 1 > f) begin
                        exp_o[f][22] = 1'b1;
                    end else begin
                        s = c + 2;
                        if (k >= 1 && acc_s[k-1] + NFFT + NCP > s) s = acc_s[k-1] + NFFT + NCP;
                        acc_s.push_back(s);
                        for (int i = 0; i < NFFT + NCP; i++) begin
                            int idx;
                            idx = (i < NCP) ? (NFFT - NCP + i) : (i - NCP);
                            if (s + i < MAXC) begin
                                exp_o[s+i][24]    = 1'b1;
                                exp_o[s+i][23]    = (i == 0);
                                exp_o[s+i][21:11] = br[idx];
                                exp_o[s+i][10:0]  = bi[idx];
                            end
                        end
                    end
                end
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        valid_i = 1'b0;
        xr_i = '0;
        xi_i = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Starts at a negedge; cycle c is the c-th rising edge after the call.
    task automatic run_stream(int n);
        for (int c = 0; c < n; c++) begin
            valid_i = stim_v[c];
            xr_i = stim_r[c];
            xi_i = stim_i[c];
            @(posedge CLK);
            #1;
            obs_o[c] = {valid_o, sym_start, overflow, yr, yi};
            @(negedge CLK);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        valid_i = 1'b0;
        #1;
        n_vec++;
        if ({valid_o, sym_start, overflow, yr, yi} !== '0) begin
            n_err++;
            $display("FAIL reset_hold got %s required all zero", fmt({valid_o, sym_start, overflow, yr, yi}));
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if ({valid_o, sym_start, overflow, yr, yi} !== '0) begin
            n_err++;
            $display("FAIL reset_idle got %s required all zero", fmt({valid_o, sym_start, overflow, yr, yi}));
        end
    endtask

    task automatic test_single();
        int first;
        int nv;
        apply_reset();
        clear_stim();
        add_sym(10, 1, 1'b1);
        model(170);
        run_stream(170);
        first = -1;
        nv = 0;
        for (int c = 0; c < 170; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL single cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][24] === 1'b1) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        n_vec++;
        if (first != 75 || nv != 80) begin
            n_err++;
            $display("FAIL single_timing got first=%0d count=%0d required first=75 count=80", first, nv);
        end
    endtask

    task automatic test_two_spaced();
        int nv;
        int nov;
        apply_reset();
        clear_stim();
        add_sym(0, 1, 1'b0);
        add_sym(80, 1, 1'b0);
        model(240);
        run_stream(240);
        nv = 0;
        nov = 0;
        for (int c = 0; c < 240; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL two_spaced cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][24] === 1'b1 && c >= 65 && c < 225) nv++;
            if (obs_o[c][22] !== 1'b0) nov++;
        end
        n_vec++;
        if (nv != 160 || nov != 0) begin
            n_err++;
            $display("FAIL two_spaced_gapless got valid=%0d ovf=%0d required valid=160 ovf=0", nv, nov);
        end
    endtask

    task automatic test_back_to_back();
        int nov;
        int at;
        apply_reset();
        clear_stim();
        add_sym(0, 1, 1'b0);
        add_sym(64, 1, 1'b0);
        add_sym(128, 1, 1'b0);
        add_sym(232, 1, 1'b0);
        model(400);
        run_stream(400);
        nov = 0;
        at = -1;
        for (int c = 0; c < 400; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][22] === 1'b1) begin
                nov++;
                at = c;
            end
        end
        n_vec++;
        if (nov != 1 || at != 128) begin
            n_err++;
            $display("FAIL back_to_back_ovf got pulses=%0d at=%0d required pulses=1 at=128", nov, at);
        end
    endtask

    task automatic test_alternate();
        int first;
        apply_reset();
        clear_stim();
        add_sym(5, 2, 1'b1);
        model(230);
        run_stream(230);
        first = -1;
        for (int c = 0; c < 230; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL alternate cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][24] === 1'b1 && first < 0) first = c;
        end
        n_vec++;
        if (first != 133) begin
            n_err++;
            $display("FAIL alternate_latency got first=%0d required 133", first);
        end
    endtask

    task automatic test_coincide();
        int nov;
        apply_reset();
        clear_stim();
        add_sym(0, 1, 1'b0);
        add_sym(64, 1, 1'b0);
        add_sym(144, 1, 1'b0);
        model(320);
        run_stream(320);
        nov = 0;
        for (int c = 0; c < 320; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL coincide cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][22] !== 1'b0) nov++;
        end
        n_vec++;
        if (nov != 0) begin
            n_err++;
            $display("FAIL coincide_ovf got pulses=%0d required 0", nov);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        apply_reset();
        clear_stim();
        add_sym(0, 1, 1'b0);
        add_sym(64, 1, 1'b0);
        model(94);
        run_stream(94);
        for (int c = 0; c < 94; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL reset_mid_pre cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
        end
        valid_i = 1'b1;
        xr_i = stim_r[94];
        xi_i = stim_i[94];
        RST = 1'b1;
        #1;
        n_vec++;
        if ({valid_o, sym_start, overflow, yr, yi} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async got %s required all zero", fmt({valid_o, sym_start, overflow, yr, yi}));
        end
        valid_i = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        clear_stim();
        add_sym(10, 1, 1'b1);
        model(170);
        run_stream(170);
        first = -1;
        for (int c = 0; c < 170; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL reset_mid_post cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
            if (obs_o[c][24] === 1'b1 && first < 0) first = c;
        end
        n_vec++;
        if (first != 75) begin
            n_err++;
            $display("FAIL reset_mid_latency got first=%0d required 75", first);
        end
    endtask

    task automatic test_random();
        apply_reset();
        clear_stim();
        for (int c = 0; c < 1600; c++) begin
            stim_v[c] = ($urandom_range(0, 99) < 80);
            stim_r[c] = W'($urandom);
            stim_i[c] = W'($urandom);
        end
        model(1850);
        run_stream(1850);
        for (int c = 0; c < 1850; c++) begin
            n_vec++;
            if (obs_o[c] !== exp_o[c]) begin
                n_err++;
                $display("FAIL random cyc=%0d got %s required %s", c, fmt(obs_o[c]), fmt(exp_o[c]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_spaced();
        test_back_to_back();
        test_alternate();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
